// File: rtl/pll_sched_pkg.sv
// Shared types and helpers for the PLL frequency scheduler: FSM state encoding,
// factor/timer widths and the packed M/D factor pair.
package pll_sched_pkg;

  localparam int FACTOR_W = 8;
  localparam int TIMER_W  = 16;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ARB        = 4'd1,
    ST_CHECK      = 4'd2,
    ST_TRIG       = 4'd3,
    ST_WAIT_START = 4'd4,
    ST_WAIT_DONE  = 4'd5,
    ST_WAIT_LOCK  = 4'd6,
    ST_ACK        = 4'd7,
    ST_ERR        = 4'd8
  } sched_state_t;

  typedef struct packed {
    logic [FACTOR_W-1:0] mul;
    logic [FACTOR_W-1:0] div;
  } pll_factor_t;

  // A zero multiply or divide factor cannot be programmed into the PLL.
  function automatic logic factor_ok(input pll_factor_t f);
    return (f.mul != {FACTOR_W{1'b0}}) && (f.div != {FACTOR_W{1'b0}});
  endfunction

  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
    return (&v) ? v : v + TIMER_W'(1);
  endfunction

endpackage

// File: rtl/pll_freq_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps;
// the pointer register itself lives in the instantiating block.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand_s;

  // First requester found walking upward from the pointer wins.
  always_comb begin
    grant_o = {N{1'b0}};
    idx_o   = {IDX_W{1'b0}};
    any_o   = 1'b0;
    cand_s  = {IDX_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      cand_s = IDX_W'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[cand_s]) begin
        any_o           = 1'b1;
        grant_o[cand_s] = 1'b1;
        idx_o           = cand_s;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/pll_freq_scheduler.sv
// Shares one reconfigurable PLL between NREQ requesters: arbitrates, skips redundant
// reconfigurations, drives the reconfig controller and waits for stable lock before acking.
module pll_freq_scheduler
  import pll_sched_pkg::*;
#(
  parameter int                  NREQ        = 2,
  parameter logic [FACTOR_W-1:0] RESET_MUL   = 8'd1,
  parameter logic [FACTOR_W-1:0] RESET_DIV   = 8'd1,
  parameter int                  START_TO    = 16,
  parameter int                  DONE_TO     = 4096,
  parameter int                  LOCK_STABLE = 64,
  parameter int                  LOCK_TO     = 65535
) (
  input  logic                       clock_ctr,
  input  logic                       sys_reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*FACTOR_W-1:0]   req_mul,
  input  logic [NREQ*FACTOR_W-1:0]   req_div,
  output logic [NREQ-1:0]            req_ack,
  output logic                       req_err,
  output logic                       rc_trigger,
  output logic [FACTOR_W-1:0]        rc_mul,
  output logic [FACTOR_W-1:0]        rc_div,
  input  logic                       rc_busy,
  input  logic                       pll_locked,
  output logic [FACTOR_W-1:0]        cur_mul,
  output logic [FACTOR_W-1:0]        cur_div,
  output logic                       cur_valid,
  output logic                       sched_busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_TO - 1);
  localparam logic [TIMER_W-1:0] DONE_LAST  = TIMER_W'(DONE_TO - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST  = TIMER_W'(LOCK_TO - 1);
  localparam logic [TIMER_W-1:0] STABLE_M1  = TIMER_W'(LOCK_STABLE - 1);
  localparam pll_factor_t        RESET_F    = '{mul: RESET_MUL, div: RESET_DIV};

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_idx_q, win_idx_d;
  pll_factor_t      req_f_q, req_f_d;
  pll_factor_t      rc_f_q, rc_f_d;
  pll_factor_t      cur_f_q, cur_f_d;
  logic             cur_valid_q, cur_valid_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [NREQ-1:0]  req_ack_q, req_ack_d;
  logic             req_err_q, req_err_d;
  logic             rc_trigger_q, rc_trigger_d;
  logic             sched_busy_q, sched_busy_d;

  pll_factor_t      req_f_s [NREQ];
  logic [NREQ-1:0]  arb_grant_s;
  logic [IDX_W-1:0] arb_idx_s;
  logic             arb_any_s;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign req_f_s[g] = {req_mul[g*FACTOR_W +: FACTOR_W], req_div[g*FACTOR_W +: FACTOR_W]};
  end

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant_s),
    .idx_o   (arb_idx_s),
    .any_o   (arb_any_s)
  );

  // Scheduler FSM and datapath next-state.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_idx_d    = win_idx_q;
    req_f_d      = req_f_q;
    rc_f_d       = rc_f_q;
    cur_f_d      = cur_f_q;
    cur_valid_d  = cur_valid_q;
    timer_d      = sat_inc(timer_q);
    lock_cnt_d   = lock_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) state_d = ST_ARB;
        else            state_d = ST_IDLE;
      end
      ST_ARB: begin
        // A request withdrawn between IDLE and ARB simply returns to IDLE.
        if (arb_any_s) begin
          win_idx_d = arb_idx_s;
          req_f_d   = req_f_s[arb_idx_s];
          ptr_d     = IDX_W'((int'(arb_idx_s) + 1) % NREQ);
          state_d   = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (!factor_ok(req_f_q)) begin
          state_d = ST_ERR;
        end else if (cur_valid_q && (req_f_q == cur_f_q)) begin
          state_d = ST_ACK;
        end else begin
          rc_f_d  = req_f_q;
          state_d = ST_TRIG;
        end
      end
      ST_TRIG: state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (rc_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q >= START_LAST) begin
          state_d     = ST_ERR;
          cur_valid_d = 1'b0;
        end else begin
          state_d = ST_WAIT_START;
        end
      end
      ST_WAIT_DONE: begin
        if (!rc_busy) begin
          state_d = ST_WAIT_LOCK;
        end else if (timer_q >= DONE_LAST) begin
          state_d     = ST_ERR;
          cur_valid_d = 1'b0;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_LOCK: begin
        // Timeout is tested first so it wins over a same-cycle lock event.
        if (timer_q >= LOCK_LAST) begin
          state_d     = ST_ERR;
          cur_valid_d = 1'b0;
        end else if (!pll_locked) begin
          lock_cnt_d = {TIMER_W{1'b0}};
        end else if (lock_cnt_q >= STABLE_M1) begin
          cur_f_d     = rc_f_q;
          cur_valid_d = 1'b1;
          state_d     = ST_ACK;
        end else begin
          lock_cnt_d = sat_inc(lock_cnt_q);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      timer_d    = {TIMER_W{1'b0}};
      lock_cnt_d = {TIMER_W{1'b0}};
    end else begin
      timer_d = timer_d;
    end

    if ((state_d == ST_ACK) || (state_d == ST_ERR)) req_ack_d = NREQ'(1) << win_idx_d;
    else                                              req_ack_d = {NREQ{1'b0}};
    req_err_d    = (state_d == ST_ERR);
    rc_trigger_d = (state_d == ST_TRIG);
    sched_busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock_ctr or posedge sys_reset) begin
    if (sys_reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= {IDX_W{1'b0}};
      win_idx_q    <= {IDX_W{1'b0}};
      req_f_q      <= RESET_F;
      rc_f_q       <= RESET_F;
      cur_f_q      <= RESET_F;
      cur_valid_q  <= 1'b1;
      timer_q      <= {TIMER_W{1'b0}};
      lock_cnt_q   <= {TIMER_W{1'b0}};
      req_ack_q    <= {NREQ{1'b0}};
      req_err_q    <= 1'b0;
      rc_trigger_q <= 1'b0;
      sched_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_idx_q    <= win_idx_d;
      req_f_q      <= req_f_d;
      rc_f_q       <= rc_f_d;
      cur_f_q      <= cur_f_d;
      cur_valid_q  <= cur_valid_d;
      timer_q      <= timer_d;
      lock_cnt_q   <= lock_cnt_d;
      req_ack_q    <= req_ack_d;
      req_err_q    <= req_err_d;
      rc_trigger_q <= rc_trigger_d;
      sched_busy_q <= sched_busy_d;
    end
  end

  assign req_ack    = req_ack_q;
  assign req_err    = req_err_q;
  assign rc_trigger = rc_trigger_q;
  assign rc_mul     = rc_f_q.mul;
  assign rc_div     = rc_f_q.div;
  assign cur_mul    = cur_f_q.mul;
  assign cur_div    = cur_f_q.div;
  assign cur_valid  = cur_valid_q;
  assign sched_busy = sched_busy_q;

endmodule
